ext_load_unit: RTL
==================

Name: ext_load_unit

Overview:
- Pipelined, parametrised load-data extender for the datapath's memory read path.
- Selects a byte, halfword or word lane from a DATA_W-bit memory read word using the address byte offset.
- Sign- or zero-extends the selected lane to DATA_W and flags misaligned or illegal requests.
- Sits between memory data output and the register-file write mux; valid/ready handshakes on both sides, with a 2-entry skid buffer so in_ready is a registered signal.

Parameters:
- DATA_W, 32, datapath width. Legal values: 32 or 64.
- OFFS_W, $clog2(DATA_W/8), width of the byte-offset field (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- in_valid  input  1  request present.
- in_ready  output  1  unit accepts the request this cycle.
- in_data  input  DATA_W  raw memory read word.
- in_offs  input  OFFS_W  address byte offset within the word.
- in_size  input  2  lane size: 00 byte, 01 half, 10 word (32-bit), 11 reserved.
- in_signed  input  1  1 = sign-extend, 0 = zero-extend.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DATA_W  extended result.
- out_err  output  1  misaligned or illegal request; qualified by out_valid.

Behaviour:
- Reset (reset==0 at a clk edge): out_valid=0, out_data=0, out_err=0, in_ready=1, skid entry invalid. Reset overrides any transfer in the same cycle; in-flight entries are discarded.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_data and out_err stay stable while out_valid && !out_ready.
  - in_valid is not required to stay asserted; in_ready does not depend combinationally on in_valid.
- Latency: 1 cycle. A request accepted at edge N appears on out_* after edge N, when the output register is free or draining that cycle.
- Storage: output register (OR) plus skid register (SR).
  - in_ready = !SR_valid, registered.
  - OR empty or draining: an accepted request loads OR.
  - OR held (out_valid && !out_ready): an accepted request loads SR and in_ready drops next cycle.
  - When OR drains and SR is valid, SR moves into OR; in_ready returns to 1 next cycle.
  - Order is preserved; no request is dropped or duplicated.
- Lane selection:
  - byte: bits [8*offs+7 : 8*offs].
  - half: bits starting at 8*offs, 16 bits.
  - word: bits starting at 8*offs, 32 bits.
- Extension: the selected lane's MSB is replicated to DATA_W when in_signed=1; the lane is zero-filled otherwise. Word on DATA_W=32 passes through unchanged regardless of in_signed.
- Error conditions (out_err=1, out_data=0):
  - half with offs[0]=1;
  - word with offs[1:0]!=0;
  - in_size=11.
  - Error entries still occupy the pipeline and complete the handshake normally.
- Extension and error evaluation are combinational on the input side; the results are registered into OR/SR. There is no combinational path from in_* to out_*.
- Simultaneous output drain and input accept with OR full and SR empty: OR takes the new request; SR stays empty.

Decomposition:
- Shared package ext_pkg:
  - size codes: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11;
  - lane width constants 8/16/32.
- Sub-module ext_lane_sel: combinational lane select, extension and error flag for one request, parametrised on DATA_W. It is instantiated once before the OR/SR registers.
- The top level holds the OR/SR handshake control.

Test Plan:
1. Reset then idle: reset=0 for 2 cycles → out_valid=0, out_data=0, out_err=0, in_ready=1; after release, in_ready stays 1.
2. Byte extension (DATA_W=32), in_data=32'h12F4_8000, out_ready=1:
   - offs=2, signed=1 → 32'hFFFF_FFF4;
   - same with signed=0 → 32'h0000_00F4;
   - offs=0, signed=1 → 32'h0000_0000;
   - each result appears 1 cycle after accept.
3. Half and word, in_data=32'hBEEF_7FFF:
   - half offs=0, signed=1 → 32'h0000_7FFF;
   - half offs=2, signed=1 → 32'hFFFF_BEEF;
   - word offs=0 → 32'hBEEF_7FFF.
4. Errors, each with out_err=1 and out_data=0, handshake completes:
   - half offs=1;
   - word offs=2;
   - size=11.
5. Backpressure: out_ready=0, send 3 back-to-back requests A,B,C →
   - A held in OR, B accepted into SR, in_ready=0 from the next cycle, C stalls;
   - raise out_ready → outputs A,B,C in order, no loss or duplication.
6. DATA_W=64, in_data=64'h8000_0001_0000_0000, word offs=4:
   - signed=1 → 64'hFFFF_FFFF_8000_0001;
   - signed=0 → 64'h0000_0000_8000_0001.
7. Reset mid-operation: reset=0 while OR and SR are both full → next cycle out_valid=0, in_ready=1, and the held entries never appear.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared definitions for the load-data extender: lane size codes and lane widths.
package ext_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam int LANE_B_W = 8;
  localparam int LANE_H_W = 16;
  localparam int LANE_W_W = 32;

endpackage

// File: rtl/ext_lane_sel.sv
// Combinational lane select, sign/zero extension and error flag for one load request.
module ext_lane_sel
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFFS_W = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [OFFS_W-1:0] offs,
  input  logic [1:0]        size,
  input  logic              sgn,
  output logic [DATA_W-1:0] res,
  output logic              err
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              msb;
  logic              bad;
  int                lane_w;

  // Shift the addressed byte to bit 0, keep lane_w bits, then fill the upper bits.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    lane_w  = LANE_B_W;
    bad     = 1'b0;
    shifted = data >> {offs, 3'b000};
    case (size)
      SZ_BYTE: lane_w = LANE_B_W;
      SZ_HALF: begin
        lane_w = LANE_H_W;
        bad    = offs[0];
      end
      SZ_WORD: begin
        lane_w = LANE_W_W;
        bad    = (offs[1:0] != 2'b00);
      end
      default: bad = 1'b1;
    endcase
    // A full-width lane makes ONE << lane_w wrap to zero, so the mask becomes all ones.
    mask = (ONE << lane_w) - ONE;
    msb  = |(shifted & (ONE << (lane_w - 1)));
    res  = shifted & mask;
    if (sgn && msb) begin
      res = res | ~mask;
    end
    if (bad) begin
      res = '0;
    end
    err = bad;
  end

endmodule

// File: rtl/ext_load_unit.sv
// Pipelined load-data extender: one extension stage feeding an output register
// backed by a skid register, so in_ready comes straight from a flop.
module ext_load_unit
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFFS_W = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFFS_W-1:0] in_offs,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [DATA_W-1:0] ext_res;
  logic              ext_err;

  logic              or_valid_q, or_valid_d;
  logic [DATA_W-1:0] or_data_q,  or_data_d;
  logic              or_err_q,   or_err_d;
  logic              sr_valid_q, sr_valid_d;
  logic [DATA_W-1:0] sr_data_q,  sr_data_d;
  logic              sr_err_q,   sr_err_d;

  logic accept;
  logic or_free;

  ext_lane_sel #(
    .DATA_W (DATA_W),
    .OFFS_W (OFFS_W)
  ) u_lane_sel (
    .data (in_data),
    .offs (in_offs),
    .size (in_size),
    .sgn  (in_signed),
    .res  (ext_res),
    .err  (ext_err)
  );

  assign in_ready  = ~sr_valid_q;
  assign accept    = in_valid & in_ready;
  assign or_free   = ~or_valid_q | out_ready;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;
  assign out_err   = or_err_q;

  // Next-state of the output/skid pair: refill OR from SR first, else from the input.
  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_err_d   = or_err_q;
    sr_valid_d = sr_valid_q;
    sr_data_d  = sr_data_q;
    sr_err_d   = sr_err_q;
    if (or_free) begin
      if (sr_valid_q) begin
        // in_ready is low while SR is full, so no new request competes here.
        or_valid_d = 1'b1;
        or_data_d  = sr_data_q;
        or_err_d   = sr_err_q;
        sr_valid_d = 1'b0;
      end else if (accept) begin
        or_valid_d = 1'b1;
        or_data_d  = ext_res;
        or_err_d   = ext_err;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      sr_valid_d = 1'b1;
      sr_data_d  = ext_res;
      sr_err_d   = ext_err;
    end
  end

  // Control and visible output state, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_err_q   <= 1'b0;
      sr_valid_q <= 1'b0;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_err_q   <= or_err_d;
      sr_valid_q <= sr_valid_d;
    end
  end

  // Skid payload register.
  always_ff @(posedge clk) begin
    // NOTE: payload is only read while sr_valid_q is set, so it needs no reset.
    sr_data_q <= sr_data_d;
    sr_err_q  <= sr_err_d;
  end

endmodule
